// File: rtl/zanagotchi_pkg.sv
// Shared pet definitions: estado codes, life-cycle FSM states and default widths.
package zanagotchi_pkg;

  localparam int unsigned ATTR_W_DEF = 8;
  localparam int unsigned ESTADO_W   = 4;

  localparam logic [ESTADO_W-1:0] EST_OCIOSO     = 4'h0;
  localparam logic [ESTADO_W-1:0] EST_SERVE_BASE = 4'h1;
  localparam logic [ESTADO_W-1:0] EST_MORTO      = 4'hF;

  typedef enum logic [1:0] {
    VIVO   = 2'd0,
    AGONIA = 2'd1,
    MORTO  = 2'd2
  } vida_t;

  // True when estado requests service of attribute idx.
  function automatic logic serve_match(input logic [ESTADO_W-1:0] estado, input int unsigned idx);
    return estado == ESTADO_W'(32'(EST_SERVE_BASE) + idx);
  endfunction

endpackage

// File: rtl/atributo_canal.sv
// One saturating attribute counter with its registered low-level flag.
module atributo_canal
  import zanagotchi_pkg::*;
#(
  parameter int unsigned ATTR_W = ATTR_W_DEF,
  parameter int unsigned INC    = 16,
  parameter int unsigned DEC    = 1,
  parameter int unsigned LIMIAR = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aplicar,
  input  logic              congelar,
  input  logic              servir,
  input  logic              encher,
  output logic [ATTR_W-1:0] valor,
  output logic              alerta,
  output logic [ATTR_W-1:0] proximo_c
);

  localparam int unsigned MAX_I   = (32'd1 << ATTR_W) - 32'd1;
  localparam int unsigned INC_SAT = (INC > MAX_I) ? MAX_I : INC;
  localparam int unsigned DEC_SAT = (DEC > MAX_I) ? MAX_I : DEC;

  localparam logic [ATTR_W:0] MAX_EXT = (ATTR_W+1)'(MAX_I);
  localparam logic [ATTR_W:0] INC_EXT = (ATTR_W+1)'(INC_SAT);
  localparam logic [ATTR_W:0] DEC_EXT = (ATTR_W+1)'(DEC_SAT);

  logic [ATTR_W:0] soma_c;
  logic [ATTR_W:0] dif_c;

  // One extra bit of headroom so both directions saturate instead of wrapping.
  always_comb begin
    soma_c    = {1'b0, valor} + INC_EXT;
    dif_c     = {1'b0, valor} - DEC_EXT;
    proximo_c = valor;
    if (encher) begin
      proximo_c = MAX_EXT[ATTR_W-1:0];
    end else if (aplicar && !congelar) begin
      if (servir) begin
        proximo_c = (soma_c > MAX_EXT) ? MAX_EXT[ATTR_W-1:0] : soma_c[ATTR_W-1:0];
      end else begin
        proximo_c = dif_c[ATTR_W] ? '0 : dif_c[ATTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor  <= MAX_EXT[ATTR_W-1:0];
      alerta <= 1'b0;
    end else begin
      valor <= proximo_c;
      if (aplicar || encher) begin
        alerta <= (32'(proximo_c) < LIMIAR);
      end
    end
  end

endmodule

// File: rtl/controlador_atributos_n.sv
// Pet attribute controller: prescaled decay tick, NUM_ATTR attribute channels and
// starvation/death tracking. Death FSM and revive handling exist only with ZANA_MORTE_EN.
module controlador_atributos_n
  import zanagotchi_pkg::*;
#(
  parameter int unsigned NUM_ATTR    = 3,
  parameter int unsigned ATTR_W      = ATTR_W_DEF,
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned INC         = 16,
  parameter int unsigned DEC         = 1,
  parameter int unsigned LIMIAR      = 32,
  parameter int unsigned MORTE_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ESTADO_W-1:0]        estado,
  input  logic                       reviver,
  output logic [NUM_ATTR*ATTR_W-1:0] valores,
  output logic [NUM_ATTR-1:0]        alerta,
  output logic                       tick,
  output logic                       morreu
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              morto_c;
  logic              restart_c;
  logic              tick_upd_c;
  logic              congelar_c;
  logic [NUM_ATTR-1:0] servir_c;
  logic [ATTR_W-1:0] proximos_c [NUM_ATTR];
  logic              algum_zero_c;

  // Prescaler: restart on revive, otherwise count 0..TICK_DIV-1.
  always_comb begin
    cnt_nxt_c = (cnt_q == CNT_ULT) ? '0 : cnt_q + CNT_W'(1);
    if (restart_c) begin
      cnt_nxt_c = '0;
    end
  end

  // tick is registered so it is high exactly while cnt_q holds the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt_c;
      tick  <= (cnt_nxt_c == CNT_ULT);
    end
  end

  always_comb begin
    tick_upd_c = tick && !morto_c;
    congelar_c = (estado == EST_MORTO);
    for (int unsigned i = 0; i < NUM_ATTR; i++) begin
      servir_c[i] = serve_match(estado, i);
    end
  end

  for (genvar g = 0; g < NUM_ATTR; g++) begin : g_canal
    atributo_canal #(
      .ATTR_W (ATTR_W),
      .INC    (INC),
      .DEC    (DEC),
      .LIMIAR (LIMIAR)
    ) u_canal (
      .clk       (clk),
      .rst_n     (rst_n),
      .aplicar   (tick_upd_c),
      .congelar  (congelar_c),
      .servir    (servir_c[g]),
      .encher    (restart_c),
      .valor     (valores[g*ATTR_W +: ATTR_W]),
      .alerta    (alerta[g]),
      .proximo_c (proximos_c[g])
    );
  end

  // Zero detection looks at the post-tick values the channels are about to load.
  always_comb begin
    algum_zero_c = 1'b0;
    for (int unsigned i = 0; i < NUM_ATTR; i++) begin
      if (proximos_c[i] == '0) begin
        algum_zero_c = 1'b1;
      end
    end
  end

`ifdef ZANA_MORTE_EN

  localparam int unsigned AG_W = $clog2(MORTE_TICKS + 1);
  localparam logic [AG_W-1:0] AG_LIM = AG_W'(MORTE_TICKS);

  vida_t           fsm_q;
  vida_t           fsm_nxt_c;
  logic [AG_W-1:0] agonia_q;
  logic [AG_W-1:0] agonia_nxt_c;
  logic [AG_W-1:0] agonia_inc_c;
  logic            morreu_nxt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= VIVO;
      agonia_q <= '0;
      morreu   <= 1'b0;
    end else begin
      fsm_q    <= fsm_nxt_c;
      agonia_q <= agonia_nxt_c;
      morreu   <= morreu_nxt_c;
    end
  end

  always_comb begin
    fsm_nxt_c    = fsm_q;
    agonia_nxt_c = agonia_q;
    morreu_nxt_c = morreu;
    agonia_inc_c = (fsm_q == VIVO) ? AG_W'(1) : agonia_q + AG_W'(1);
    case (fsm_q)
      VIVO, AGONIA: begin
        if (tick) begin
          if (algum_zero_c) begin
            agonia_nxt_c = agonia_inc_c;
            if (agonia_inc_c >= AG_LIM) begin
              fsm_nxt_c    = MORTO;
              morreu_nxt_c = 1'b1;
            end else begin
              fsm_nxt_c = AGONIA;
            end
          end else begin
            fsm_nxt_c    = VIVO;
            agonia_nxt_c = '0;
          end
        end
      end
      MORTO: begin
        if (reviver) begin
          fsm_nxt_c    = VIVO;
          agonia_nxt_c = '0;
          morreu_nxt_c = 1'b0;
        end
      end
      default: begin
        fsm_nxt_c    = VIVO;
        agonia_nxt_c = '0;
        morreu_nxt_c = 1'b0;
      end
    endcase
  end

  assign morto_c   = (fsm_q == MORTO);
  assign restart_c = morto_c && reviver;

`else

  logic unused_c;

  assign morto_c   = 1'b0;
  assign restart_c = 1'b0;
  assign morreu    = 1'b0;
  assign unused_c  = reviver ^ algum_zero_c;

`endif

endmodule

// File: tb/tb_controlador_atributos_n.sv
// Self-checking bench for controlador_atributos_n: tick-level vector table, death/revive
// and reset corner sequences, then random stimulus against a behavioural pet model.
module tb_controlador_atributos_n;

  localparam int NA = 3;
  localparam int W  = 4;
  localparam int TD = 4;
  localparam int INC_P = 3;
  localparam int DEC_P = 1;
  localparam int LIM = 4;
  localparam int MT  = 2;
  localparam int MAXV = 15;
`ifdef ZANA_MORTE_EN
  localparam bit MORTE_EN = 1'b1;
`else
  localparam bit MORTE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      estado;
  logic            reviver;
  logic [NA*W-1:0] valores;
  logic [NA-1:0]   alerta;
  logic            tick;
  logic            morreu;

  controlador_atributos_n #(
    .NUM_ATTR(NA), .ATTR_W(W), .TICK_DIV(TD), .INC(INC_P), .DEC(DEC_P),
    .LIMIAR(LIM), .MORTE_TICKS(MT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .reviver(reviver),
    .valores(valores), .alerta(alerta), .tick(tick), .morreu(morreu)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the pet
  int m_val [NA];
  bit m_al  [NA];
  int m_phase;
  bit m_tick;
  bit m_dead;
  int m_zrun;

  typedef struct {
    logic [3:0] est;
    int         reps;
    int         v0, v1, v2;
    logic [2:0] al;
  } vec_t;

  vec_t tab [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_val[i] = MAXV;
      m_al[i]  = 1'b0;
    end
    m_phase = 0;
    m_tick  = 1'b0;
    m_dead  = 1'b0;
    m_zrun  = 0;
  endtask

  task automatic model_step(input logic [3:0] e, input logic r);
    bit any_zero;
    if (MORTE_EN && m_dead && r) begin
      for (int i = 0; i < NA; i++) begin
        m_val[i] = MAXV;
        m_al[i]  = (MAXV < LIM);
      end
      m_dead  = 1'b0;
      m_zrun  = 0;
      m_phase = 0;
      m_tick  = 1'b0;
    end else begin
      if (m_tick && !m_dead) begin
        any_zero = 1'b0;
        for (int i = 0; i < NA; i++) begin
          if (e != 4'hF) begin
            if (int'(e) == i + 1) m_val[i] = (m_val[i] + INC_P > MAXV) ? MAXV : m_val[i] + INC_P;
            else                  m_val[i] = (m_val[i] - DEC_P < 0) ? 0 : m_val[i] - DEC_P;
          end
          m_al[i] = (m_val[i] < LIM);
          if (m_val[i] == 0) any_zero = 1'b1;
        end
        if (MORTE_EN) begin
          if (any_zero) begin
            m_zrun++;
            if (m_zrun >= MT) m_dead = 1'b1;
          end else begin
            m_zrun = 0;
          end
        end
      end
      m_phase = (m_phase + 1) % TD;
      m_tick  = (m_phase == TD - 1);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NA; i++) begin
      check($sformatf("%s valor[%0d]", tag, i), 32'(valores[i*W +: W]), 32'(m_val[i]));
      check($sformatf("%s alerta[%0d]", tag, i), 32'(alerta[i]), 32'(m_al[i]));
    end
    check({tag, " tick"}, 32'(tick), 32'(m_tick));
    check({tag, " morreu"}, 32'(morreu), 32'(m_dead));
  endtask

  // One clock: apply inputs at negedge, advance model, sample at the following negedge.
  task automatic cycle(input logic [3:0] e, input logic r, input bit do_check);
    estado  = e;
    reviver = r;
    model_step(e, r);
    @(posedge clk);
    @(negedge clk);
    reviver = 1'b0;
    if (do_check) check_model("model");
  endtask

  task automatic run_ticks(input logic [3:0] e, input int n);
    for (int k = 0; k < n * TD; k++) cycle(e, 1'b0, 1'b0);
  endtask

  task automatic check_vals(input string tag, input int a0, input int a1, input int a2);
    check({tag, " v0"}, 32'(valores[0 +: W]), 32'(a0));
    check({tag, " v1"}, 32'(valores[W +: W]), 32'(a1));
    check({tag, " v2"}, 32'(valores[2*W +: W]), 32'(a2));
  endtask

  initial begin
    tab[0] = '{4'h0, 1, 14, 14, 14, 3'b000};
    tab[1] = '{4'h2, 1, 13, 15, 13, 3'b000};
    tab[2] = '{4'h2, 1, 12, 15, 12, 3'b000};
    tab[3] = '{4'h1, 1, 15, 14, 11, 3'b000};
    tab[4] = '{4'h3, 1, 14, 13, 14, 3'b000};
    tab[5] = '{4'h7, 1, 13, 12, 13, 3'b000};
    tab[6] = '{4'hF, 1, 13, 12, 13, 3'b000};
    tab[7] = '{4'h0, 9,  4,  3,  4, 3'b010};
    tab[8] = '{4'h0, 1,  3,  2,  3, 3'b111};

    rst_n   = 1'b0;
    estado  = 4'h0;
    reviver = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check_vals("reset", MAXV, MAXV, MAXV);
    check("reset alerta", 32'(alerta), 32'(0));
    check("reset tick", 32'(tick), 32'(0));
    check("reset morreu", 32'(morreu), 32'(0));

    cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0);
    check("tick early", 32'(tick), 32'(0));
    cycle(4'h0, 1'b0, 1'b0);
    check("first tick", 32'(tick), 32'(1));
    cycle(4'h0, 1'b0, 1'b0);
    check("tick one cycle", 32'(tick), 32'(0));
    check_vals("tick1", 14, 14, 14);

    for (int t = 1; t < 9; t++) begin
      run_ticks(tab[t].est, tab[t].reps);
      check_vals($sformatf("row%0d", t), tab[t].v0, tab[t].v1, tab[t].v2);
      check($sformatf("row%0d alerta", t), 32'(alerta), 32'(tab[t].al));
      check($sformatf("row%0d morreu", t), 32'(morreu), 32'(0));
    end

    run_ticks(4'h0, 1);
    check_vals("pre-agony", 2, 1, 2);
    run_ticks(4'h0, 1);
    check_vals("first zero", 1, 0, 1);
    check("first zero morreu", 32'(morreu), 32'(0));
    run_ticks(4'h0, 1);
    check_vals("second zero", 0, 0, 0);
    check("death", 32'(morreu), 32'(MORTE_EN));
    run_ticks(4'h0, 2);
    check_vals("held at zero", 0, 0, 0);
    check("death sticky", 32'(morreu), 32'(MORTE_EN));

    // Revive pulse coincident with a tick cycle
    for (int k = 0; k < TD && !m_tick; k++) cycle(4'h0, 1'b0, 1'b0);
    check("revive sync tick", 32'(tick), 32'(1));
    cycle(4'h0, 1'b1, 1'b1);
    if (MORTE_EN) begin
      check_vals("revive", MAXV, MAXV, MAXV);
      check("revive morreu", 32'(morreu), 32'(0));
      check("revive tick", 32'(tick), 32'(0));
      for (int k = 0; k < 3; k++) begin
        cycle(4'h0, 1'b0, 1'b0);
        check($sformatf("revive tick+%0d", k + 2), 32'(tick), 32'(k == 2));
      end
    end else begin
      check_vals("reviver ignored", 0, 0, 0);
      check("reviver ignored morreu", 32'(morreu), 32'(0));
    end

    // Reset asserted mid-agony and mid-tick
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_ticks(4'h0, 15);
    check_vals("agony again", 0, 0, 0);
    check("agony again morreu", 32'(morreu), 32'(0));
    cycle(4'h0, 1'b0, 1'b0);
    cycle(4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_vals("async reset", MAXV, MAXV, MAXV);
    check("async reset alerta", 32'(alerta), 32'(0));
    check("async reset morreu", 32'(morreu), 32'(0));
    check("async reset tick", 32'(tick), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_model("post reset");

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] e;
      logic       r;
      int         sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      e = 4'h0;
      else if (sel < 8) e = 4'($urandom_range(1, 3));
      else              e = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 15) == 0);
      cycle(e, r, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
